// File: rtl/lsc_pkg.sv
// Shared types, funct3 encodings and small decode helpers for the
// load/store controller.
package lsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } lscState_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Stores only know B/H/W; loads add the two unsigned variants.
  function automatic logic isLegalF3(input logic isStore, input logic [2:0] funct3);
    if (isStore) return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

  // Bits [1:0] of funct3 encode the access size for every legal code.
  function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLo);
    case (funct3[1:0])
      2'd1:    return addrLo[0];
      2'd2:    return addrLo != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] calcBe(input logic [2:0] funct3, input logic [1:0] addrLo);
    case (funct3[1:0])
      2'd0:    return 4'b0001 << addrLo;
      2'd1:    return addrLo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the datum into every lane lets the byte enables pick the
  // right one without a shifter.
  function automatic logic [31:0] alignStore(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3[1:0])
      2'd0:    return {4{wdata[7:0]}};
      2'd1:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_store_controller_if.sv
// Request-side and memory-side signals of the load/store controller.
interface load_store_controller_if;

  logic        lsc_start;
  logic        lsc_is_store;
  logic [2:0]  lsc_funct3;
  logic [31:0] lsc_addr;
  logic [31:0] lsc_wdata;
  logic        lsc_mem_req;
  logic        lsc_mem_we;
  logic [31:0] lsc_mem_addr;
  logic [3:0]  lsc_mem_be;
  logic [31:0] lsc_mem_wdata;
  logic [31:0] lsc_mem_rdata;
  logic        lsc_mem_ready;
  logic [31:0] lsc_load_data;
  logic        lsc_busy;
  logic        lsc_done;
  logic        lsc_err;

  // Controller side.
  modport slave (
    input  lsc_start, lsc_is_store, lsc_funct3, lsc_addr, lsc_wdata,
           lsc_mem_rdata, lsc_mem_ready,
    output lsc_mem_req, lsc_mem_we, lsc_mem_addr, lsc_mem_be, lsc_mem_wdata,
           lsc_load_data, lsc_busy, lsc_done, lsc_err
  );

  // Requester and memory model side.
  modport master (
    output lsc_start, lsc_is_store, lsc_funct3, lsc_addr, lsc_wdata,
           lsc_mem_rdata, lsc_mem_ready,
    input  lsc_mem_req, lsc_mem_we, lsc_mem_addr, lsc_mem_be, lsc_mem_wdata,
           lsc_load_data, lsc_busy, lsc_done, lsc_err
  );

endinterface

// File: rtl/load_store_controller_align_extend.sv
// Picks the addressed byte/half out of a read word and extends it to 32 bits.
module load_align_extend
  import lsc_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_byteOff,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_loadData
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = i_rdata >> {i_byteOff, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_byteOff[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Extension is chosen purely from funct3; illegal codes never reach here.
  always_comb begin
    o_loadData = i_rdata;
    case (i_funct3)
      F3_B:    o_loadData = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_loadData = {24'd0, w_byte};
      F3_H:    o_loadData = {{16{w_half[15]}}, w_half};
      F3_HU:   o_loadData = {16'd0, w_half};
      default: o_loadData = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_controller.sv
// Single-outstanding load/store controller: validates a request, drives one
// memory transaction with a bounded wait, and keeps the last load result.
module load_store_controller
  import lsc_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input logic lsc_clk,
  input logic lsc_rst,
  load_store_controller_if.slave bus
);

  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  lscState_t          r_state;
  logic               r_isStore;
  logic [2:0]         r_funct3;
  logic [1:0]         r_addrLo;
  logic [CNT_W-1:0]   r_waitCnt;
  logic [31:0]        r_loadData;
  logic               r_memReq;
  logic               r_memWe;
  logic [31:0]        r_memAddr;
  logic [3:0]         r_memBe;
  logic [31:0]        r_memWdata;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [31:0]        w_extended;

  load_align_extend u_align (
    .i_rdata    (bus.lsc_mem_rdata),
    .i_byteOff  (r_addrLo),
    .i_funct3   (r_funct3),
    .o_loadData (w_extended)
  );

  // FSM with all outputs registered; the bus fields are set once on entry to
  // REQ so they stay stable for the whole transaction.
  always_ff @(posedge lsc_clk or posedge lsc_rst) begin
    if (lsc_rst) begin
      r_state    <= ST_IDLE;
      r_isStore  <= 1'b0;
      r_funct3   <= 3'd0;
      r_addrLo   <= 2'd0;
      r_waitCnt  <= '0;
      r_loadData <= 32'd0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= 32'd0;
      r_memBe    <= 4'd0;
      r_memWdata <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.lsc_start) begin
            r_isStore <= bus.lsc_is_store;
            r_funct3  <= bus.lsc_funct3;
            r_addrLo  <= bus.lsc_addr[1:0];
            r_busy    <= 1'b1;
            if (!isLegalF3(bus.lsc_is_store, bus.lsc_funct3) ||
                isMisaligned(bus.lsc_funct3, bus.lsc_addr[1:0])) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state    <= ST_REQ;
              r_waitCnt  <= '0;
              r_memReq   <= 1'b1;
              r_memWe    <= bus.lsc_is_store;
              r_memAddr  <= {bus.lsc_addr[31:2], 2'b00};
              r_memBe    <= calcBe(bus.lsc_funct3, bus.lsc_addr[1:0]);
              r_memWdata <= alignStore(bus.lsc_funct3, bus.lsc_wdata);
            end
          end
        end
        ST_REQ: begin
          if (bus.lsc_mem_ready || (r_waitCnt == CNT_W'(WAIT_LIMIT - 1))) begin
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= 32'd0;
            r_memBe    <= 4'd0;
            r_memWdata <= 32'd0;
            if (bus.lsc_mem_ready) begin
              if (!r_isStore) r_loadData <= w_extended;
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end
          end else begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lsc_mem_req   = r_memReq;
  assign bus.lsc_mem_we    = r_memWe;
  assign bus.lsc_mem_addr  = r_memAddr;
  assign bus.lsc_mem_be    = r_memBe;
  assign bus.lsc_mem_wdata = r_memWdata;
  assign bus.lsc_load_data = r_loadData;
  assign bus.lsc_busy      = r_busy;
  assign bus.lsc_done      = r_done;
  assign bus.lsc_err       = r_err;

endmodule
